// File: rtl/bcd_time_counter.sv
// MM:SS stopwatch digit source for the VGA clock painter.
// Start/stop/clear with up/down count, manual set while stopped, expiry flag.
module bcd_time_counter #(
    parameter int TICK_DIV = 50_000_000,
    parameter int PRESC_W  = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       count_down,
    input  logic       inc_min,
    input  logic       inc_sec,
    output logic [3:0] mDecimal,
    output logic [3:0] mUnit,
    output logic [3:0] sDecimal,
    output logic [3:0] sUnit,
    output logic       running,
    output logic       expired,
    output logic       tick
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    state_t state, state_n;
    logic [PRESC_W-1:0] presc, presc_n;
    logic dir, dir_n;
    logic [15:0] tm, tm_n;
    logic tick_n;

    // bit order: {inc_sec, inc_min, count_down, clear, start_stop}
    logic [4:0] s1, s2;
    logic [2:0] dly;
    logic start_e, inc_m_e, inc_s_e, clr, cnt_dn;
    logic step;
    logic [15:0] tm_up, tm_dn, tm_set;

    function automatic logic [7:0] inc60(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    function automatic logic [7:0] dec60(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v[3:0] == 4'd0) begin
            r[3:0] = 4'd9;
            r[7:4] = (v[7:4] == 4'd0) ? 4'd5 : v[7:4] - 4'd1;
        end else begin
            r[3:0] = v[3:0] - 4'd1;
        end
        return r;
    endfunction

    assign start_e = s2[0] & ~dly[0];
    assign clr     = s2[1];
    assign cnt_dn  = s2[2];
    assign inc_m_e = s2[3] & ~dly[1];
    assign inc_s_e = s2[4] & ~dly[2];

    assign step = (state == RUN) && (presc == PRESC_MAX);

    assign tm_up[7:0]  = inc60(tm[7:0]);
    assign tm_up[15:8] = (tm[7:0] == 8'h59) ? inc60(tm[15:8]) : tm[15:8];

    // 00:00 is held rather than wrapped to 59:59
    assign tm_dn = (tm == 16'h0000) ? tm :
                   {((tm[7:0] == 8'h00) ? dec60(tm[15:8]) : tm[15:8]),
                    dec60(tm[7:0])};

    assign tm_set = {(inc_m_e ? inc60(tm[15:8]) : tm[15:8]),
                     (inc_s_e ? inc60(tm[7:0]) : tm[7:0])};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= '0;
            s2    <= '0;
            dly   <= '0;
            presc <= '0;
            dir   <= 1'b0;
            tm    <= '0;
            tick  <= 1'b0;
        end else begin
            s1    <= {inc_sec, inc_min, count_down, clear, start_stop};
            s2    <= s1;
            dly   <= {s2[4], s2[3], s2[0]};
            presc <= presc_n;
            dir   <= dir_n;
            tm    <= tm_n;
            tick  <= tick_n;
        end
    end

    always_comb begin
        state_n = state;
        presc_n = presc;
        dir_n   = dir;
        tm_n    = tm;
        tick_n  = 1'b0;
        if (clr) begin
            state_n = IDLE;
            presc_n = '0;
            dir_n   = 1'b0;
            tm_n    = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_e) begin
                        if (!(cnt_dn && tm == 16'h0000)) begin
                            state_n = RUN;
                            presc_n = '0;
                            dir_n   = cnt_dn;
                        end
                    end else begin
                        tm_n = tm_set;
                    end
                end
                RUN: begin
                    presc_n = step ? '0 : presc + 1'b1;
                    if (step) begin
                        tick_n = 1'b1;
                        tm_n   = dir ? tm_dn : tm_up;
                        if (dir && tm_n == 16'h0000) state_n = DONE;
                    end
                    if (start_e && state_n == RUN) state_n = PAUSE;
                end
                PAUSE: begin
                    if (start_e) state_n = RUN;
                    else tm_n = tm_set;
                end
                DONE: begin
                    if (start_e) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign mDecimal = tm[15:12];
    assign mUnit    = tm[11:8];
    assign sDecimal = tm[7:4];
    assign sUnit    = tm[3:0];
    assign running  = (state == RUN);
    assign expired  = (state == DONE);

endmodule
